// File: rtl/usr_serial_ctrl_if.sv
// usr_serial_ctrl_if: word-in, bit-out and USR-side signals of the serial sequencer
interface usr_serial_ctrl_if #(parameter int WIDTH = 4);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] usr_parin;
  logic [WIDTH-1:0] usr_out;
  logic [1:0] usr_sel;
  logic ser_out;
  logic ser_valid;
  logic ser_ready;
  logic ser_last;
  modport master(output in_valid, in_data, usr_out, ser_ready,
                 input in_ready, usr_parin, usr_sel, ser_out, ser_valid, ser_last);
  modport slave(input in_valid, in_data, usr_out, ser_ready,
                output in_ready, usr_parin, usr_sel, ser_out, ser_valid, ser_last);
endinterface

// File: rtl/usr_serial_ctrl.sv
// usr_serial_ctrl: sequences a universal shift register as a parallel-to-serial converter
module usr_serial_ctrl #(
  parameter int WIDTH = 4,
  parameter bit LSB_FIRST = 1'b1,
  parameter int IDLE_GAP = 0
) (
  input logic clk,
  input logic clr,
  input logic abort,
  output logic busy,
  usr_serial_ctrl_if.slave bus
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [1:0] SHIFT_SEL = LSB_FIRST ? 2'b01 : 2'b10;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] bitcnt, bitcnt_nx;
  logic [3:0] gapcnt, gapcnt_nx;
  logic [WIDTH-1:0] parin;
  logic armed, in_ready, ser_valid, ser_last, last;
  logic [1:0] sel;
  // armed keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      state <= IDLE;
      bitcnt <= '0;
      gapcnt <= '0;
      parin <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      bitcnt <= bitcnt_nx;
      gapcnt <= gapcnt_nx;
      armed <= 1'b1;
      if (in_ready && bus.in_valid) parin <= bus.in_data;
    end
  always_comb begin
    state_nx = state;
    bitcnt_nx = bitcnt;
    gapcnt_nx = gapcnt;
    sel = 2'b00;
    in_ready = 1'b0;
    ser_valid = 1'b0;
    ser_last = 1'b0;
    last = bitcnt == CW'(WIDTH - 1);
    case (state)
      IDLE: begin
        in_ready = armed;
        state_nx = armed && bus.in_valid ? LOAD : IDLE;
      end
      LOAD: begin
        sel = 2'b11;
        state_nx = SHIFT;
        bitcnt_nx = '0;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_last = last;
        if (bus.ser_ready) begin
          sel = SHIFT_SEL;
          bitcnt_nx = last ? '0 : CW'(bitcnt + 1'b1);
          if (last && IDLE_GAP > 0) begin
            state_nx = GAP;
            gapcnt_nx = '0;
          end else if (last) begin
            in_ready = 1'b1;
            state_nx = bus.in_valid ? LOAD : IDLE;
          end
        end
      end
      GAP: begin
        gapcnt_nx = gapcnt == 4'(IDLE_GAP - 1) ? '0 : 4'(gapcnt + 1'b1);
        state_nx = gapcnt == 4'(IDLE_GAP - 1) ? IDLE : GAP;
      end
    endcase
    // abort drops the word in flight and wins over both handshakes
    if (abort) begin
      state_nx = IDLE;
      bitcnt_nx = '0;
      gapcnt_nx = '0;
      sel = 2'b00;
      in_ready = 1'b0;
      ser_valid = 1'b0;
      ser_last = 1'b0;
    end
  end
  assign busy = state != IDLE;
  assign bus.in_ready = in_ready;
  assign bus.usr_parin = parin;
  assign bus.usr_sel = sel;
  assign bus.ser_valid = ser_valid;
  assign bus.ser_last = ser_last;
  assign bus.ser_out = LSB_FIRST ? bus.usr_out[0] : bus.usr_out[WIDTH-1];
endmodule

// File: tb/tb_usr_serial_ctrl.sv
// tb_usr_serial_ctrl: three controller configurations, each driving a behavioural USR
module tb_usr_serial_ctrl;
  logic clk = 1'b0;
  logic clr = 1'b0;
  logic [2:0] in_valid = '0;
  logic [2:0] abort = '0;
  logic [2:0] ser_ready = '1;
  logic [3:0] in_data [3];
  logic [2:0] in_ready, ser_out, ser_valid, ser_last, busy;
  logic [1:0] sel [3];
  int checks = 0;
  int errors = 0;
  int xfers [3] = '{0, 0, 0};
  logic [3:0] sbq [$];
  always #5 clk = ~clk;
  // instance 0: LSB first, no gap; 1: MSB first, no gap; 2: LSB first, gap of 2
  for (genvar k = 0; k < 3; k++) begin : g
    usr_serial_ctrl_if #(.WIDTH(4)) bus ();
    logic [3:0] usr_q = '0;
    always @(posedge clk)
      case (bus.usr_sel)
        2'b11: usr_q <= bus.usr_parin;
        2'b01: usr_q <= {1'b0, usr_q[3:1]};
        2'b10: usr_q <= {usr_q[2:0], 1'b0};
        default: usr_q <= usr_q;
      endcase
    assign bus.in_valid = in_valid[k];
    assign bus.in_data = in_data[k];
    assign bus.ser_ready = ser_ready[k];
    assign bus.usr_out = usr_q;
    assign in_ready[k] = bus.in_ready;
    assign ser_out[k] = bus.ser_out;
    assign ser_valid[k] = bus.ser_valid;
    assign ser_last[k] = bus.ser_last;
    assign sel[k] = bus.usr_sel;
    usr_serial_ctrl #(.WIDTH(4), .LSB_FIRST(k == 1 ? 1'b0 : 1'b1), .IDLE_GAP(k == 2 ? 2 : 0)) dut (
      .clk(clk), .clr(clr), .abort(abort[k]), .busy(busy[k]), .bus(bus.slave));
  end
  always @(negedge clk)
    for (int k = 0; k < 3; k++)
      if (ser_valid[k] && ser_ready[k]) begin
        checks++;
        xfers[k]++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_extra inst %0d: got bit=%0b last=%0b with nothing expected", k, ser_out[k], ser_last[k]);
        end else begin
          logic [3:0] e;
          e = sbq.pop_front();
          if (e != {2'(k), ser_out[k], ser_last[k]})
            begin
              errors++;
              $display("FAIL sb_bit inst %0d: got inst/bit/last=%0d/%0b/%0b expected %0d/%0b/%0b",
                       k, k, ser_out[k], ser_last[k], e[3:2], e[1], e[0]);
            end
        end
      end
  task automatic cmp(string tag, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic cyc(int k, logic [1:0] s, int rdy, int bsy, string tag);
    @(negedge clk);
    cmp({tag, " sel"}, int'(sel[k]), int'(s));
    if (rdy >= 0) cmp({tag, " in_ready"}, int'(in_ready[k]), rdy);
    if (bsy >= 0) cmp({tag, " busy"}, int'(busy[k]), bsy);
    @(posedge clk);
    #1;
  endtask
  task automatic push_word(int k, logic [3:0] seq);
    for (int i = 3; i >= 0; i--) sbq.push_back({2'(k), seq[i], i == 0});
  endtask
  task automatic start(int k, logic [3:0] d, logic [3:0] seq, logic [1:0] sh, string tag);
    push_word(k, seq);
    in_valid[k] = 1'b1;
    in_data[k] = d;
    cyc(k, 2'b00, 1, 0, {tag, " accept"});
    in_valid[k] = 1'b0;
    cyc(k, 2'b11, 0, 1, {tag, " load"});
    repeat (4) cyc(k, sh, -1, 1, {tag, " shift"});
  endtask
  task automatic partial_then(int k);
    sbq.push_back({2'(k), 1'b1, 1'b0});
    sbq.push_back({2'(k), 1'b1, 1'b0});
    in_valid[k] = 1'b1;
    in_data[k] = 4'b1011;
    cyc(k, 2'b00, 1, 0, "part accept");
    in_valid[k] = 1'b0;
    cyc(k, 2'b11, 0, 1, "part load");
    cyc(k, 2'b01, 0, 1, "part bit0");
    cyc(k, 2'b01, 0, 1, "part bit1");
  endtask
  initial begin
    for (int k = 0; k < 3; k++) in_data[k] = '0;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 2'b00, 0, 0, "t1 in_reset");
    in_valid[0] = 1'b0;
    clr = 1'b1;
    cyc(0, 2'b00, 0, 0, "t1 release");
    cyc(0, 2'b00, 1, 0, "t1 ready");
    start(0, 4'b1011, 4'b1101, 2'b01, "t2");
    cyc(0, 2'b00, 1, 0, "t2 end");
    start(1, 4'b1011, 4'b1011, 2'b10, "t3");
    cyc(1, 2'b00, 1, 0, "t3 end");
    begin
      int x0;
      x0 = xfers[0];
      push_word(0, 4'b1101);
      in_valid[0] = 1'b1;
      in_data[0] = 4'b1011;
      cyc(0, 2'b00, 1, 0, "t4 accept");
      in_valid[0] = 1'b0;
      cyc(0, 2'b11, 0, 1, "t4 load");
      cyc(0, 2'b01, 0, 1, "t4 bit0");
      cyc(0, 2'b01, 0, 1, "t4 bit1");
      ser_ready[0] = 1'b0;
      repeat (3) begin
        @(negedge clk);
        cmp("t4 stall sel", int'(sel[0]), 0);
        cmp("t4 stall ser_out", int'(ser_out[0]), 0);
        cmp("t4 stall ser_valid", int'(ser_valid[0]), 1);
        cmp("t4 stall ser_last", int'(ser_last[0]), 0);
        @(posedge clk);
        #1;
      end
      ser_ready[0] = 1'b1;
      cyc(0, 2'b01, 0, 1, "t4 bit2");
      cyc(0, 2'b01, 1, 1, "t4 bit3");
      cyc(0, 2'b00, 1, 0, "t4 end");
      cmp("t4 xfers", xfers[0] - x0, 4);
    end
    push_word(0, 4'b1101);
    push_word(0, 4'b0110);
    in_valid[0] = 1'b1;
    in_data[0] = 4'b1011;
    cyc(0, 2'b00, 1, 0, "t5 accept");
    in_data[0] = 4'b0110;
    cyc(0, 2'b11, 0, 1, "t5 load");
    repeat (3) cyc(0, 2'b01, 0, 1, "t5 shift");
    cyc(0, 2'b01, 1, 1, "t5 handoff");
    in_valid[0] = 1'b0;
    cyc(0, 2'b11, 0, 1, "t5 load2");
    repeat (4) cyc(0, 2'b01, -1, 1, "t5 shift2");
    cyc(0, 2'b00, 1, 0, "t5 end");
    push_word(2, 4'b1101);
    push_word(2, 4'b0110);
    in_valid[2] = 1'b1;
    in_data[2] = 4'b1011;
    cyc(2, 2'b00, 1, 0, "t5g accept");
    in_data[2] = 4'b0110;
    cyc(2, 2'b11, 0, 1, "t5g load");
    repeat (4) cyc(2, 2'b01, 0, 1, "t5g shift");
    repeat (2) cyc(2, 2'b00, 0, 1, "t5g gap");
    cyc(2, 2'b00, 1, 0, "t5g accept2");
    in_valid[2] = 1'b0;
    cyc(2, 2'b11, 0, 1, "t5g load2");
    repeat (4) cyc(2, 2'b01, 0, 1, "t5g shift2");
    repeat (2) cyc(2, 2'b00, 0, 1, "t5g gap2");
    cyc(2, 2'b00, 1, 0, "t5g end");
    partial_then(0);
    abort[0] = 1'b1;
    in_valid[0] = 1'b1;
    @(negedge clk);
    cmp("t6 abort sel", int'(sel[0]), 0);
    cmp("t6 abort in_ready", int'(in_ready[0]), 0);
    cmp("t6 abort ser_valid", int'(ser_valid[0]), 0);
    cmp("t6 abort ser_last", int'(ser_last[0]), 0);
    @(posedge clk);
    #1;
    abort[0] = 1'b0;
    in_valid[0] = 1'b0;
    cyc(0, 2'b00, 1, 0, "t6 idle");
    start(0, 4'b0001, 4'b1000, 2'b01, "t6 next");
    cyc(0, 2'b00, 1, 0, "t6 end");
    partial_then(0);
    clr = 1'b0;
    #1;
    cmp("t6c clr busy", int'(busy[0]), 0);
    cmp("t6c clr sel", int'(sel[0]), 0);
    cmp("t6c clr ser_valid", int'(ser_valid[0]), 0);
    cmp("t6c clr in_ready", int'(in_ready[0]), 0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    cyc(0, 2'b00, 0, 0, "t6c release");
    cyc(0, 2'b00, 1, 0, "t6c ready");
    start(0, 4'b0001, 4'b1000, 2'b01, "t6c next");
    cyc(0, 2'b00, 1, 0, "t6c end");
    cmp("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
